// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO and launch sequencer feeding UART_TX; define UART_TXQ_LEVEL_EN to add the o_Level count port
module uart_tx_queue #(
  parameter int DEPTH    = 16,
  parameter int GAP_CLKS = 0
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic       i_Wr_DV,
  input  logic [7:0] i_Wr_Data,
  output logic       o_Full,
  output logic       o_Empty,
  output logic       o_Overflow,
  output logic       o_Busy,
  output logic       o_TX_Start,
  output logic [7:0] o_TX_Data,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done
`ifdef UART_TXQ_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] o_Level
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int GW = GAP_CLKS > 1 ? $clog2(GAP_CLKS) : 1;
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;
  state_t state, state_nxt;
  logic [7:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count, count_nxt;
  logic [GW-1:0] gap_cnt;
  logic push, pop, gap_end;
  assign push = i_Wr_DV && !o_Full;
  assign count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  always_ff @(posedge i_Clock)
    state <= i_Reset ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = pop ? START : IDLE;
      START:     state_nxt = WAIT_DONE;
      WAIT_DONE: state_nxt = i_TX_Done ? (GAP_CLKS > 0 ? GAP : IDLE) : WAIT_DONE;
      GAP:       state_nxt = gap_end ? IDLE : GAP;
      default:   state_nxt = IDLE;
    endcase
  end
  always_comb begin
    pop = state == IDLE && i_Enable && !o_Empty && !i_TX_Active;
    gap_end = gap_cnt == GW'(GAP_CLKS - 1);
    o_Busy = state != IDLE;
  end
  always_ff @(posedge i_Clock)
    if (push) mem[wr_ptr] <= i_Wr_Data;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
      o_TX_Start <= 1'b0;
      o_TX_Data  <= 8'h00;
      gap_cnt    <= '0;
    end else begin
      wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr     <= pop ? rd_ptr + 1'b1 : rd_ptr;
      o_TX_Data  <= pop ? mem[rd_ptr] : o_TX_Data;
      count      <= count_nxt;
      o_Full     <= count_nxt == (PW+1)'(DEPTH);
      o_Empty    <= count_nxt == '0;
      o_Overflow <= o_Overflow || (i_Wr_DV && o_Full);
      o_TX_Start <= pop;
      gap_cnt    <= state == GAP ? gap_cnt + 1'b1 : '0;
    end
  end
`ifdef UART_TXQ_LEVEL_EN
  assign o_Level = count;
`endif
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for uart_tx_queue with a behavioural UART_TX stand-in
module tb_uart_tx_queue;
  localparam int DEPTH = 16;
  localparam int GAP   = 5;
  localparam int FRAME = 8;
  logic clk = 0;
  logic rst = 1, en = 0, wr_dv = 0;
  logic [7:0] wr_data = 0;
  logic full, empty, ovf, busy, start;
  logic [7:0] tx_data;
  logic tx_active = 0, tx_done = 0;
`ifdef UART_TXQ_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif
  always #10 clk = ~clk;
  uart_tx_queue #(.DEPTH(DEPTH), .GAP_CLKS(GAP)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Enable(en), .i_Wr_DV(wr_dv), .i_Wr_Data(wr_data),
    .o_Full(full), .o_Empty(empty), .o_Overflow(ovf), .o_Busy(busy),
    .o_TX_Start(start), .o_TX_Data(tx_data), .i_TX_Active(tx_active), .i_TX_Done(tx_done)
`ifdef UART_TXQ_LEVEL_EN
    , .o_Level(level)
`endif
  );
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int start_cnt = 0, start_cyc = 0, tx_cnt = 0, done_cyc = 0;
  bit live = 0, ovf_exp = 0, gap_armed = 0, inflight = 0;
  logic [7:0] mq [$];
  logic [7:0] cur_byte = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      ovf_exp = 0;
      gap_armed = 0;
      inflight = 0;
      live = 1;
    end else begin
      if (!en) gap_armed = 0;
      if (wr_dv) begin
        if (mq.size() < DEPTH) mq.push_back(wr_data);
        else ovf_exp = 1;
      end
    end
  end
  always @(negedge clk) if (live) begin
    tx_done = 0;
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
      if (gap_armed) begin
        chk("gap", cyc - done_cyc, GAP + 2);
        gap_armed = 0;
      end
      if (mq.size() == 0) chk("spurious_start", 1, 0);
      else begin
        cur_byte = mq.pop_front();
        chk("tx_data", tx_data, cur_byte);
      end
      chk("busy_on_start", busy, 1);
      tx_active = 1;
      tx_cnt = FRAME;
      inflight = 1;
    end else if (tx_cnt > 0) begin
      if (inflight) chk("data_hold", tx_data, cur_byte);
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_active = 0;
        tx_done = 1;
        done_cyc = cyc;
        gap_armed = inflight && en && !rst && mq.size() > 0;
      end
    end
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("overflow", ovf, ovf_exp);
`ifdef UART_TXQ_LEVEL_EN
    chk("level", level, mq.size());
`endif
  end
  task automatic push(input logic [7:0] b);
    wr_dv = 1;
    wr_data = b;
    @(negedge clk);
    wr_dv = 0;
  endtask
  task automatic wait_start(input int n);
    int t = 0;
    while (start_cnt < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("start_timeout", start_cnt, n);
  endtask
  task automatic drain();
    int t = 0;
    while ((mq.size() != 0 || tx_active || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("drain_timeout", mq.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int s0, c0;
    logic [7:0] burst [4] = '{8'hA5, 8'h5A, 8'h00, 8'hFF};
    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_data", tx_data, 8'h00);
    rst = 0;
    en = 1;
    repeat (2) @(negedge clk);
    s0 = start_cnt;
    c0 = cyc;
    push(8'h3F);
    wait_start(s0 + 1);
    chk("latency", start_cyc, c0 + 2);
    drain();
    chk("t1_empty", empty, 1);
    chk("t1_busy", busy, 0);
    chk("t1_data_kept", tx_data, 8'h3F);
    s0 = start_cnt;
    foreach (burst[i]) push(burst[i]);
    drain();
    chk("t2_starts", start_cnt - s0, 4);
    en = 0;
    s0 = start_cnt;
    for (int i = 1; i <= DEPTH + 1; i++) push(8'(i));
    chk("t3_full", full, 1);
    chk("t3_ovf", ovf, 1);
    chk("t3_held", start_cnt - s0, 0);
    en = 1;
    drain();
    chk("t3_starts", start_cnt - s0, DEPTH);
    chk("t3_ovf_sticky", ovf, 1);
    s0 = start_cnt;
    repeat (10) push(8'($urandom));
    drain();
    repeat (10) push(8'($urandom));
    drain();
    chk("t4_starts", start_cnt - s0, 20);
    s0 = start_cnt;
    push(8'h31);
    push(8'h32);
    push(8'h33);
    wait_start(s0 + 2);
    en = 0;
    repeat (FRAME + GAP + 10) @(negedge clk);
    chk("t5_starts", start_cnt - s0, 2);
    chk("t5_pending", empty, 0);
    chk("t5_busy", busy, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t5_rst_empty", empty, 1);
    chk("t5_rst_ovf", ovf, 0);
    chk("t5_rst_data", tx_data, 8'h00);
    chk("t5_rst_busy", busy, 0);
    en = 1;
    s0 = start_cnt;
    repeat (40) @(negedge clk);
    chk("t5_no_start", start_cnt - s0, 0);
    repeat (400) begin
      wr_dv = $urandom_range(0, 2) == 0;
      wr_data = 8'($urandom);
      en = $urandom_range(0, 7) != 0;
      @(negedge clk);
    end
    wr_dv = 0;
    en = 1;
    drain();
    chk("final_empty", empty, 1);
    chk("final_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
